// File: rtl/ring_buffer.sv
// ring_buffer: single-clock circular FIFO with registered output.
// Wrapping read/write pointers; full/empty are decoded from the count.
module ring_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_WIDTH-1:0]        datain,
   output logic [DATA_WIDTH-1:0]        dataout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic                  push_ok;
   logic                  pop_ok;

   // A full buffer still takes a push when a pop frees a slot that edge.
   always_comb begin
      pop_ok  = enable & pop & ~empty;
      push_ok = enable & push & (~full | pop);
   end

   always_comb begin
      full  = (count == CW'(DEPTH));
      empty = (count == '0);
   end

   // Storage is deliberately not cleared by reset.
   always_ff @(posedge clock) begin
      if (reset && push_ok) begin
         mem[wptr] <= datain;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         dataout <= '0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + AW'(1);
         end
         if (pop_ok) begin
            rptr    <= rptr + AW'(1);
            dataout <= mem[rptr];
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_buffer.sv
// tb_ring_buffer: scoreboard-driven bench for ring_buffer.
// A queue model tracks accepted pushes/pops and the expected dataout.
module tb_ring_buffer;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       push;
   logic       pop;
   logic [7:0] datain;
   logic [7:0] dataout;
   logic       full;
   logic       empty;
   logic [4:0] count;

   int n_cmp;
   int n_bad;

   logic [7:0] sb[$];
   logic [7:0] exp_dout;

   ring_buffer #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable),
      .push    (push),
      .pop     (pop),
      .datain  (datain),
      .dataout (dataout),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cycle(input logic e, input logic pu,
                        input logic po, input logic [7:0] d);
      logic pa;
      logic wa;
      reset  = 1'b1;
      enable = e;
      push   = pu;
      pop    = po;
      datain = d;
      if (e) begin
         pa = po && (sb.size() > 0);
         wa = pu && ((sb.size() < 16) || po);
         if (pa) exp_dout = sb.pop_front();
         if (wa) sb.push_back(d);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic rst_cycle(input logic e, input logic pu, input logic po);
      reset  = 1'b0;
      enable = e;
      push   = pu;
      pop    = po;
      datain = 8'hA5;
      sb.delete();
      exp_dout = 8'h00;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      rst_cycle(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (dataout !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_dout got %0d want 0", dataout);
      end
      n_cmp++;
      if (count !== 5'd0) begin
         n_bad++;
         $display("FAIL reset_count got %0d want 0", count);
      end
      n_cmp++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags got e=%b f=%b want e=1 f=0",
                  empty, full);
      end
   endtask

   task automatic test_basic_order();
      cycle(1, 1, 0, 8'd10);
      cycle(1, 1, 0, 8'd20);
      cycle(1, 1, 0, 8'd30);
      n_cmp++;
      if (count !== 5'd3 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_fill got c=%0d e=%b want c=3 e=0",
                  count, empty);
      end
      cycle(1, 0, 1, 8'd0);
      n_cmp++;
      if (dataout !== 8'd10) begin
         n_bad++;
         $display("FAIL basic_pop1 got %0d want 10", dataout);
      end
      cycle(1, 0, 1, 8'd0);
      n_cmp++;
      if (dataout !== 8'd20 || count !== 5'd1) begin
         n_bad++;
         $display("FAIL basic_pop2 got d=%0d c=%0d want d=20 c=1",
                  dataout, count);
      end
   endtask

   task automatic test_underflow();
      cycle(1, 1, 0, 8'd40);
      cycle(1, 1, 0, 8'd50);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 1, 8'd0);
         n_cmp++;
         if (dataout !== exp_dout || count !== 5'(sb.size())) begin
            n_bad++;
            $display("FAIL uflow_pop%0d got d=%0d c=%0d want d=%0d c=%0d",
                     i, dataout, count, exp_dout, sb.size());
         end
      end
      n_cmp++;
      if (dataout !== 8'd50 || empty !== 1'b1 || count !== 5'd0) begin
         n_bad++;
         $display("FAIL uflow_hold got d=%0d e=%b c=%0d want d=50 e=1 c=0",
                  dataout, empty, count);
      end
      cycle(1, 1, 1, 8'd60);
      n_cmp++;
      if (dataout !== 8'd50 || count !== 5'd1) begin
         n_bad++;
         $display("FAIL empty_both got d=%0d c=%0d want d=50 c=1",
                  dataout, count);
      end
      cycle(1, 0, 1, 8'd0);
      n_cmp++;
      if (dataout !== 8'd60 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL empty_both_pop got d=%0d e=%b want d=60 e=1",
                  dataout, empty);
      end
   endtask

   task automatic test_wraparound();
      for (int i = 1; i <= 10; i++) cycle(1, 1, 0, 8'(i));
      for (int i = 1; i <= 9; i++) begin
         cycle(1, 0, 1, 8'd0);
         n_cmp++;
         if (dataout !== 8'(i)) begin
            n_bad++;
            $display("FAIL wrap_pop%0d got %0d want %0d", i, dataout, i);
         end
      end
      n_cmp++;
      if (count !== 5'd1) begin
         n_bad++;
         $display("FAIL wrap_count got %0d want 1", count);
      end
      for (int i = 11; i <= 25; i++) begin
         n_cmp++;
         if (full !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_early_full at c=%0d got 1 want 0", count);
         end
         cycle(1, 1, 0, 8'(i));
      end
      n_cmp++;
      if (full !== 1'b1 || count !== 5'd16) begin
         n_bad++;
         $display("FAIL wrap_full got f=%b c=%0d want f=1 c=16",
                  full, count);
      end
      cycle(1, 1, 0, 8'd77);
      n_cmp++;
      if (full !== 1'b1 || count !== 5'd16 || dataout !== 8'd9) begin
         n_bad++;
         $display("FAIL over_push got f=%b c=%0d d=%0d want f=1 c=16 d=9",
                  full, count, dataout);
      end
   endtask

   task automatic test_full_both();
      cycle(1, 1, 1, 8'd99);
      n_cmp++;
      if (dataout !== 8'd10 || count !== 5'd16 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL full_both got d=%0d c=%0d f=%b want d=10 c=16 f=1",
                  dataout, count, full);
      end
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 1, 8'd0);
         n_cmp++;
         if (dataout !== exp_dout || count !== 5'(sb.size())) begin
            n_bad++;
            $display("FAIL drain%0d got d=%0d c=%0d want d=%0d c=%0d",
                     i, dataout, count, exp_dout, sb.size());
         end
      end
      n_cmp++;
      if (dataout !== 8'd99 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_last got d=%0d e=%b want d=99 e=1",
                  dataout, empty);
      end
   endtask

   task automatic test_enable();
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 8'(100 + i));
      cycle(0, 1, 0, 8'd200);
      cycle(0, 0, 1, 8'd0);
      cycle(0, 1, 1, 8'd201);
      n_cmp++;
      if (count !== 5'd5 || dataout !== 8'd99) begin
         n_bad++;
         $display("FAIL enable_hold got c=%0d d=%0d want c=5 d=99",
                  count, dataout);
      end
      cycle(1, 0, 1, 8'd0);
      n_cmp++;
      if (dataout !== 8'd100 || count !== 5'd4) begin
         n_bad++;
         $display("FAIL enable_resume got d=%0d c=%0d want d=100 c=4",
                  dataout, count);
      end
      cycle(1, 1, 0, 8'd105);
   endtask

   task automatic test_reset_mid();
      n_cmp++;
      if (count !== 5'd5) begin
         n_bad++;
         $display("FAIL mid_pre got %0d want 5", count);
      end
      rst_cycle(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (count !== 5'd0 || dataout !== 8'd0 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset got c=%0d d=%0d e=%b want c=0 d=0 e=1",
                  count, dataout, empty);
      end
      cycle(1, 0, 1, 8'd0);
      n_cmp++;
      if (dataout !== 8'd0 || count !== 5'd0) begin
         n_bad++;
         $display("FAIL mid_lost got d=%0d c=%0d want d=0 c=0",
                  dataout, count);
      end
      cycle(1, 1, 0, 8'd42);
      cycle(1, 1, 1, 8'd43);
      n_cmp++;
      if (dataout !== 8'd42 || count !== 5'd1) begin
         n_bad++;
         $display("FAIL mid_after got d=%0d c=%0d want d=42 c=1",
                  dataout, count);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      exp_dout = 8'h00;
      reset    = 1'b1;
      enable   = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      datain   = 8'h00;
      @(posedge clock);
      #1;
      test_reset();
      test_basic_order();
      test_underflow();
      test_wraparound();
      test_full_both();
      test_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
